alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, operand and result width.
REQ-002 Parameter CONTROL_WIDTH, default 5, ALU operation code width; encodings are those of the team's ALU, e.g. ADD=5'b00000, SUB=5'b00001, SLT=5'b00110.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 arst_i  input  1  asynchronous, active-high reset.
REQ-005 reqN_valid_i  input  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready_o  output  1  requester N operation accepted this cycle.
REQ-007 reqN_op_i  input  CONTROL_WIDTH  requester N ALU operation code.
REQ-008 reqN_src_1_i, reqN_src_2_i  input  DATA_WIDTH  requester N operands.
REQ-009 rspN_valid_o  output  1  requester N response buffer holds a result.
REQ-010 rspN_ready_i  input  1  requester N consumes its response.
REQ-011 rspN_result_o  output  DATA_WIDTH  buffered result for requester N.
REQ-012 rspN_flags_o  output  3  buffered {zero, lt, ltu} flags for requester N.
REQ-013 alu_control_o  output  CONTROL_WIDTH  operation code driven to the shared ALU.
REQ-014 alu_src_1_o, alu_src_2_o  output  DATA_WIDTH  operands driven to the shared ALU.
REQ-015 alu_result_i  input  DATA_WIDTH  combinational result from the shared ALU.
REQ-016 zero_flag_i, lt_flag_i, ltu_flag_i  input  1  combinational flags from the shared ALU.

Function
REQ-017 The block SHALL share one combinational ALU between two requesters, granting at most one operation per cycle.
REQ-018 Requester N is eligible when reqN_valid_i=1 and its response buffer is empty, or full with rspN_ready_i=1 in the same cycle.
REQ-019 Grant selection SHALL use a one-bit round-robin pointer. When both requesters are eligible, the pointed-to requester wins; when one is eligible, it wins regardless of the pointer.
REQ-020 After any grant, the pointer SHALL point to the requester that did not win. Without a grant, the pointer SHALL hold.
REQ-021 reqN_ready_o SHALL be 1 exactly in the cycle requester N is granted. It is combinational from valid, buffer state and pointer, and is never asserted without reqN_valid_i.
REQ-022 In a grant cycle, alu_control_o, alu_src_1_o and alu_src_2_o SHALL carry the winner's op and operands combinationally.
REQ-023 Without a grant, the ALU outputs SHALL be ADD with both operands zero.
REQ-024 On the grant-cycle edge, alu_result_i and the flags SHALL be captured into the winner's response buffer, and rspN_valid_o SHALL rise. Latency from acceptance to rspN_valid_o is exactly 1 cycle.
REQ-025 Each response buffer holds one entry. The buffer clears when rspN_valid_o=1 and rspN_ready_i=1, unless a new result is written on the same edge; the write takes precedence and valid stays 1.
REQ-026 Buffered result and flags SHALL hold stable while rspN_valid_o=1 and rspN_ready_i=0.
REQ-027 Requester operands may change freely after acceptance; the buffer is unaffected.
REQ-028 Full throughput: one requester with rspN_ready_i tied 1 SHALL be accepted every cycle. Two such requesters SHALL alternate, each accepted every other cycle.
REQ-029 A requester with a full, unconsumed buffer SHALL not block the other requester.

Reset
REQ-030 While arst_i=1, asynchronously:
- rsp0_valid_o = rsp1_valid_o = 0
- result buffers and flags = 0
- pointer = requester 0
REQ-031 While arst_i=1, req0_ready_o = req1_ready_o = 0 and the ALU outputs SHALL be ADD with zero operands.
REQ-032 An operation offered or buffered when reset asserts SHALL be discarded; no response appears after deassertion.
REQ-033 The first edge after deassertion SHALL be able to grant.

Verification
REQ-034 Single op: req0 valid, op=ADD, src 5 and 7, rsp0_ready_i=1 -> req0_ready_o=1 that cycle; next cycle rsp0_valid_o=1, result=12, flags=3'b000.
REQ-035 Contention: both valid every cycle, both rsp ready tied 1, after reset -> grants 0,1,0,1...; req1 SUB 3-3 gives result 0, flags 3'b100.
REQ-036 Backpressure: req1 SLT src -1 vs 1, rsp1_ready_i=0 -> result 1, flags 3'b010 held. Further req1 ops stall while req0 ops continue every cycle. Raising rsp1_ready_i re-grants req1 in that same cycle.
REQ-037 Simultaneous pop/push: rsp0 full, rsp0_ready_i=1, req0 valid -> buffer replaced on that edge, rsp0_valid_o stays 1, no bubble.
REQ-038 Reset mid-operation: arst_i pulsed during a grant cycle with req1 pointed -> rsp valids 0 immediately; after release with both valid, requester 0 granted first.
REQ-039 Idle: no valid for 10 cycles -> ALU outputs ADD/0/0 throughout, pointer unchanged, no rsp valid.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals around alu_arbiter.
// The arbiter takes the slave view; the requesters and ALU side take the master view.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int CONTROL_WIDTH = 5
);
    logic                     req0_valid_i;
    logic                     req0_ready_o;
    logic [CONTROL_WIDTH-1:0] req0_op_i;
    logic [DATA_WIDTH-1:0]    req0_src_1_i;
    logic [DATA_WIDTH-1:0]    req0_src_2_i;
    logic                     req1_valid_i;
    logic                     req1_ready_o;
    logic [CONTROL_WIDTH-1:0] req1_op_i;
    logic [DATA_WIDTH-1:0]    req1_src_1_i;
    logic [DATA_WIDTH-1:0]    req1_src_2_i;

    logic                     rsp0_valid_o;
    logic                     rsp0_ready_i;
    logic [DATA_WIDTH-1:0]    rsp0_result_o;
    logic [2:0]               rsp0_flags_o;
    logic                     rsp1_valid_o;
    logic                     rsp1_ready_i;
    logic [DATA_WIDTH-1:0]    rsp1_result_o;
    logic [2:0]               rsp1_flags_o;

    logic [CONTROL_WIDTH-1:0] alu_control_o;
    logic [DATA_WIDTH-1:0]    alu_src_1_o;
    logic [DATA_WIDTH-1:0]    alu_src_2_o;
    logic [DATA_WIDTH-1:0]    alu_result_i;
    logic                     zero_flag_i;
    logic                     lt_flag_i;
    logic                     ltu_flag_i;

    modport slave (
        input  req0_valid_i, req0_op_i, req0_src_1_i, req0_src_2_i,
        input  req1_valid_i, req1_op_i, req1_src_1_i, req1_src_2_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp0_result_o, rsp0_flags_o,
        output rsp1_valid_o, rsp1_result_o, rsp1_flags_o,
        input  rsp0_ready_i, rsp1_ready_i,
        output alu_control_o, alu_src_1_o, alu_src_2_o,
        input  alu_result_i, zero_flag_i, lt_flag_i, ltu_flag_i
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_src_1_i, req0_src_2_i,
        output req1_valid_i, req1_op_i, req1_src_1_i, req1_src_2_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp0_result_o, rsp0_flags_o,
        input  rsp1_valid_o, rsp1_result_o, rsp1_flags_o,
        output rsp0_ready_i, rsp1_ready_i,
        input  alu_control_o, alu_src_1_o, alu_src_2_o,
        output alu_result_i, zero_flag_i, lt_flag_i, ltu_flag_i
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// each with a single-entry response buffer.
module alu_arbiter #(
    parameter int DATA_WIDTH    = 64,
    parameter int CONTROL_WIDTH = 5
) (
    input  logic         clk_i,
    input  logic         arst_i,
    alu_arbiter_if.slave bus
);
    localparam logic [CONTROL_WIDTH-1:0] OP_ADD = '0;

    logic                  ptr_q, ptr_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic [DATA_WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic [2:0]            rsp0_flags_q, rsp0_flags_d;
    logic [2:0]            rsp1_flags_q, rsp1_flags_d;

    logic       elig0, elig1, grant0, grant1;
    logic [2:0] alu_flags;

    assign alu_flags = {bus.zero_flag_i, bus.lt_flag_i, bus.ltu_flag_i};

    // A full buffer being drained this cycle frees the slot for a new result.
    assign elig0  = bus.req0_valid_i && (!rsp0_valid_q || bus.rsp0_ready_i);
    assign elig1  = bus.req1_valid_i && (!rsp1_valid_q || bus.rsp1_ready_i);
    assign grant0 = !arst_i && elig0 && (!elig1 || !ptr_q);
    assign grant1 = !arst_i && elig1 && (!elig0 ||  ptr_q);

    assign bus.req0_ready_o  = grant0;
    assign bus.req1_ready_o  = grant1;
    assign bus.rsp0_valid_o  = rsp0_valid_q;
    assign bus.rsp1_valid_o  = rsp1_valid_q;
    assign bus.rsp0_result_o = rsp0_result_q;
    assign bus.rsp1_result_o = rsp1_result_q;
    assign bus.rsp0_flags_o  = rsp0_flags_q;
    assign bus.rsp1_flags_o  = rsp1_flags_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        bus.alu_control_o = OP_ADD;
        bus.alu_src_1_o   = '0;
        bus.alu_src_2_o   = '0;
        if (grant0) begin
            bus.alu_control_o = bus.req0_op_i;
            bus.alu_src_1_o   = bus.req0_src_1_i;
            bus.alu_src_2_o   = bus.req0_src_2_i;
        end else if (grant1) begin
            bus.alu_control_o = bus.req1_op_i;
            bus.alu_src_1_o   = bus.req1_src_1_i;
            bus.alu_src_2_o   = bus.req1_src_2_i;
        end
    end

    always_comb begin
        ptr_d         = ptr_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;
        rsp0_flags_d  = rsp0_flags_q;
        rsp1_flags_d  = rsp1_flags_q;

        if (grant0)      ptr_d = 1'b1;
        else if (grant1) ptr_d = 1'b0;

        // A write on the same edge as a pop wins, keeping the buffer full.
        if (grant0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = bus.alu_result_i;
            rsp0_flags_d  = alu_flags;
        end else if (rsp0_valid_q && bus.rsp0_ready_i) begin
            rsp0_valid_d  = 1'b0;
        end

        if (grant1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = bus.alu_result_i;
            rsp1_flags_d  = alu_flags;
        end else if (rsp1_valid_q && bus.rsp1_ready_i) begin
            rsp1_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        // NOTE: the result buffers are reset too, because their contents are
        // visible on the response outputs and must read zero out of reset.
        if (arst_i) begin
            ptr_q         <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_flags_q  <= '0;
            rsp1_flags_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            ptr_q         <= ptr_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            rsp0_flags_q  <= rsp0_flags_d;
            rsp1_flags_q  <= rsp1_flags_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table for arbitration and buffering,
// plus hand sequences for backpressure, pop/push, reset and idle behaviour.
module tb_alu_arbiter;
    localparam int DW = 64;
    localparam int CW = 5;
    localparam logic [CW-1:0] ADD  = 5'b00000;
    localparam logic [CW-1:0] SUB  = 5'b00001;
    localparam logic [CW-1:0] SLT  = 5'b00110;
    localparam logic [CW-1:0] SLTU = 5'b00111;
    localparam logic [DW-1:0] M1   = {DW{1'b1}};

    logic clk_i = 1'b0;
    logic arst_i;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    alu_arbiter_if #(.DATA_WIDTH(DW), .CONTROL_WIDTH(CW)) bus ();
    alu_arbiter #(.DATA_WIDTH(DW), .CONTROL_WIDTH(CW)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus.slave)
    );

    // Stand-in for the team ALU: comparison flags only for compare-type ops.
    always_comb begin
        logic is_cmp;
        is_cmp = (bus.alu_control_o == SUB) || (bus.alu_control_o == SLT) ||
                 (bus.alu_control_o == SLTU);
        case (bus.alu_control_o)
            SUB:     bus.alu_result_i = bus.alu_src_1_o - bus.alu_src_2_o;
            SLT:     bus.alu_result_i = DW'($signed(bus.alu_src_1_o) < $signed(bus.alu_src_2_o));
            SLTU:    bus.alu_result_i = DW'(bus.alu_src_1_o < bus.alu_src_2_o);
            default: bus.alu_result_i = bus.alu_src_1_o + bus.alu_src_2_o;
        endcase
        bus.zero_flag_i = (bus.alu_result_i == '0);
        bus.lt_flag_i   = is_cmp && ($signed(bus.alu_src_1_o) < $signed(bus.alu_src_2_o));
        bus.ltu_flag_i  = is_cmp && (bus.alu_src_1_o < bus.alu_src_2_o);
    end

    typedef struct {
        logic          v0, v1;
        logic [CW-1:0] op0, op1;
        logic [DW-1:0] a0, b0, a1, b1;
        logic          rr0, rr1;
        logic          rdy0, rdy1;
        logic [CW-1:0] e_op;
        logic [DW-1:0] e_s1, e_s2;
        logic          rv0, rv1;
        logic [DW-1:0] r0, r1;
        logic [2:0]    f0, f1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [CW-1:0] op0, input logic [DW-1:0] a0, b0,
                         input logic v1, input logic [CW-1:0] op1, input logic [DW-1:0] a1, b1,
                         input logic rr0, input logic rr1);
        bus.req0_valid_i = v0;  bus.req0_op_i = op0;
        bus.req0_src_1_i = a0;  bus.req0_src_2_i = b0;
        bus.req1_valid_i = v1;  bus.req1_op_i = op1;
        bus.req1_src_1_i = a1;  bus.req1_src_2_i = b1;
        bus.rsp0_ready_i = rr0; bus.rsp1_ready_i = rr1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_alu(input string name, input logic [CW-1:0] op,
                             input logic [DW-1:0] s1, input logic [DW-1:0] s2);
        check({name, "_op"}, DW'(bus.alu_control_o), DW'(op));
        check({name, "_s1"}, bus.alu_src_1_o, s1);
        check({name, "_s2"}, bus.alu_src_2_o, s2);
    endtask

    task automatic do_reset();
        arst_i = 1'b1;
        drive(0, ADD, 0, 0, 0, ADD, 0, 0, 0, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;
    endtask

    initial begin
        //          v0 v1 op0  op1  a0 b0 a1 b1 rr0 rr1 rdy0 rdy1 e_op e_s1 e_s2 rv0 rv1 r0  r1 f0      f1
        vecs[0] = '{0, 0, ADD, ADD, 0, 0, 0, 0, 1,  1,  0,   0,   ADD, 0,   0,   0,  0,  0,  0, 3'b000, 3'b000};
        vecs[1] = '{1, 0, ADD, ADD, 5, 7, 0, 0, 1,  1,  1,   0,   ADD, 5,   7,   0,  0,  0,  0, 3'b000, 3'b000};
        vecs[2] = '{0, 0, ADD, ADD, 0, 0, 0, 0, 1,  1,  0,   0,   ADD, 0,   0,   1,  0, 12,  0, 3'b000, 3'b000};
        vecs[3] = '{1, 1, ADD, SUB, 1, 2, 3, 3, 1,  1,  0,   1,   SUB, 3,   3,   0,  0,  0,  0, 3'b000, 3'b000};
        vecs[4] = '{1, 1, ADD, SUB, 1, 2, 3, 3, 1,  1,  1,   0,   ADD, 1,   2,   0,  1,  0,  0, 3'b000, 3'b100};
        vecs[5] = '{1, 1, ADD, SUB, 1, 2, 3, 3, 1,  1,  0,   1,   SUB, 3,   3,   1,  0,  3,  0, 3'b000, 3'b000};
        vecs[6] = '{0, 0, ADD, ADD, 0, 0, 0, 0, 1,  1,  0,   0,   ADD, 0,   0,   0,  1,  0,  0, 3'b000, 3'b100};

        // Reset state, checked while reset is held.
        arst_i = 1'b1;
        drive(1, SUB, 9, 4, 1, SUB, 8, 2, 1, 1);
        #3;
        check("rst_rdy0", DW'(bus.req0_ready_o), 0);
        check("rst_rdy1", DW'(bus.req1_ready_o), 0);
        check("rst_rv0", DW'(bus.rsp0_valid_o), 0);
        check("rst_rv1", DW'(bus.rsp1_valid_o), 0);
        check("rst_r0", bus.rsp0_result_o, 0);
        check_alu("rst_alu", ADD, 0, 0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0,
                  vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].rr0, vecs[i].rr1);
            #4;
            check($sformatf("v%0d_rdy0", i), DW'(bus.req0_ready_o), DW'(vecs[i].rdy0));
            check($sformatf("v%0d_rdy1", i), DW'(bus.req1_ready_o), DW'(vecs[i].rdy1));
            check_alu($sformatf("v%0d_alu", i), vecs[i].e_op, vecs[i].e_s1, vecs[i].e_s2);
            check($sformatf("v%0d_rv0", i), DW'(bus.rsp0_valid_o), DW'(vecs[i].rv0));
            check($sformatf("v%0d_rv1", i), DW'(bus.rsp1_valid_o), DW'(vecs[i].rv1));
            if (vecs[i].rv0) begin
                check($sformatf("v%0d_r0", i), bus.rsp0_result_o, vecs[i].r0);
                check($sformatf("v%0d_f0", i), DW'(bus.rsp0_flags_o), DW'(vecs[i].f0));
            end
            if (vecs[i].rv1) begin
                check($sformatf("v%0d_r1", i), bus.rsp1_result_o, vecs[i].r1);
                check($sformatf("v%0d_f1", i), DW'(bus.rsp1_flags_o), DW'(vecs[i].f1));
            end
            step();
        end

        // Backpressure on requester 1 while requester 0 keeps flowing.
        do_reset();
        drive(0, ADD, 0, 0, 1, SLT, M1, 1, 1, 0);
        #4;
        check("bp0_rdy1", DW'(bus.req1_ready_o), 1);
        check_alu("bp0_alu", SLT, M1, 1);
        step();
        drive(1, ADD, 10, 20, 1, SLT, 5, 6, 1, 0);
        #4;
        check("bp1_rv1", DW'(bus.rsp1_valid_o), 1);
        check("bp1_r1", bus.rsp1_result_o, 1);
        check("bp1_f1", DW'(bus.rsp1_flags_o), 3'b010);
        check("bp1_rdy1", DW'(bus.req1_ready_o), 0);
        check("bp1_rdy0", DW'(bus.req0_ready_o), 1);
        step();
        drive(1, ADD, 11, 20, 1, SLT, 5, 6, 1, 0);
        #4;
        check("bp2_rdy0", DW'(bus.req0_ready_o), 1);
        check("bp2_rdy1", DW'(bus.req1_ready_o), 0);
        check("bp2_r1", bus.rsp1_result_o, 1);
        check("bp2_f1", DW'(bus.rsp1_flags_o), 3'b010);
        check("bp2_r0", bus.rsp0_result_o, 30);
        step();
        bus.rsp1_ready_i = 1'b1;
        #4;
        check("bp3_rdy1", DW'(bus.req1_ready_o), 1);
        check("bp3_rdy0", DW'(bus.req0_ready_o), 0);
        check_alu("bp3_alu", SLT, 5, 6);
        check("bp3_r0", bus.rsp0_result_o, 31);
        step();
        drive(1, ADD, 0, 0, 0, ADD, 0, 0, 1, 1);
        #4;
        check("bp4_rv1", DW'(bus.rsp1_valid_o), 1);
        check("bp4_r1", bus.rsp1_result_o, 1);
        check("bp4_f1", DW'(bus.rsp1_flags_o), 3'b011);
        step();

        // Pop and push on the same edge: no bubble in rsp0_valid_o.
        do_reset();
        drive(1, ADD, 1, 1, 0, ADD, 0, 0, 1, 1);
        step();
        drive(1, ADD, 2, 2, 0, ADD, 0, 0, 1, 1);
        #4;
        check("pp1_rv0", DW'(bus.rsp0_valid_o), 1);
        check("pp1_r0", bus.rsp0_result_o, 2);
        check("pp1_rdy0", DW'(bus.req0_ready_o), 1);
        step();
        drive(0, ADD, 0, 0, 0, ADD, 0, 0, 1, 1);
        #4;
        check("pp2_rv0", DW'(bus.rsp0_valid_o), 1);
        check("pp2_r0", bus.rsp0_result_o, 4);
        step();
        #4;
        check("pp3_rv0", DW'(bus.rsp0_valid_o), 0);
        step();

        // Reset pulsed during a grant cycle with requester 1 pointed to.
        do_reset();
        drive(1, ADD, 1, 1, 0, ADD, 0, 0, 1, 1);
        step();
        drive(1, ADD, 2, 2, 1, SUB, 9, 4, 1, 1);
        #2;
        check("rm_rdy1_pre", DW'(bus.req1_ready_o), 1);
        #1;
        arst_i = 1'b1;
        #1;
        check("rm_rv0", DW'(bus.rsp0_valid_o), 0);
        check("rm_rv1", DW'(bus.rsp1_valid_o), 0);
        check("rm_rdy1", DW'(bus.req1_ready_o), 0);
        check_alu("rm_alu", ADD, 0, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        #3;
        check("rm_post_rdy0", DW'(bus.req0_ready_o), 1);
        check("rm_post_rdy1", DW'(bus.req1_ready_o), 0);
        check("rm_post_rv0", DW'(bus.rsp0_valid_o), 0);
        check("rm_post_rv1", DW'(bus.rsp1_valid_o), 0);
        check_alu("rm_post_alu", ADD, 2, 2);
        step();

        // Idle for 10 cycles; pointer (now at requester 1) must hold.
        drive(0, ADD, 5, 5, 0, SUB, 6, 6, 1, 1);
        for (int i = 0; i < 10; i++) begin
            #4;
            check_alu($sformatf("idle%0d_alu", i), ADD, 0, 0);
            check($sformatf("idle%0d_rdy", i), DW'({bus.req0_ready_o, bus.req1_ready_o}), 0);
            if (i > 0)
                check($sformatf("idle%0d_rv", i), DW'({bus.rsp0_valid_o, bus.rsp1_valid_o}), 0);
            step();
        end
        drive(1, ADD, 5, 5, 1, SUB, 6, 6, 1, 1);
        #4;
        check("idle_ptr_rdy1", DW'(bus.req1_ready_o), 1);
        check("idle_ptr_rdy0", DW'(bus.req0_ready_o), 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
